shifter_seq: RTL and testbench
==============================

// Module: shifter_seq
// PURPOSE
//  Multi-cycle, parametrised operand-2 shifter for the datapath. Decodes the instruction class, then
//  iterates STEP bit positions per clock. Supports immediate rotate, shift-by-immediate,
//  shift-by-register (new), RRX and proper ASR sign fill (new), and ARM shifter carry-out (new).
//  Produces branch offsets and imm12 pass-through. Sits between the register file read ports and the ALU B input.
//  Start/Busy/Done handshake to the control unit.
// PARAMETERS
//  WIDTH  32  datapath width; >=32; instruction fields are fixed, results extend to WIDTH
//  STEP   1   bit positions shifted per SHIFT cycle; power of 2, 1..WIDTH
// PORTS
//  Clk            in   1      clock; one clock; reset is synchronous and active-low
//  Reset          in   1      synchronous active-low reset
//  Start          in   1      load operands and begin; honoured only in IDLE
//  InstructionReg in   32     instruction word
//  Rm             in   WIDTH  operand to shift
//  Rs             in   WIDTH  shift-amount register; only Rs[7:0] is used
//  CarryIn        in   1      current CPSR C flag
//  O              out  WIDTH  shifter operand result
//  CarryOut       out  1      shifter carry-out
//  Busy           out  1      high in SHIFT
//  Done           out  1      one-cycle pulse; O/CarryOut valid from this cycle until the next Start
// BEHAVIOUR
//  Reset (Reset==0 at posedge): state=IDLE; O=0, CarryOut=0, Busy=0, Done=0. Aborts any operation in flight.
//  States: IDLE -(Start)-> SHIFT -(cnt==0)-> DONE -> IDLE. Start is ignored outside IDLE.
//  Load (Start in IDLE): latch operands; set working value W, carry C, count cnt, op; enter SHIFT.
//   [27:25]=001 rotate imm: W=zext(imm8), op=ROR, cnt=2*[11:8], C=CarryIn.
//   [27:25]=000,[4]=0 shift imm, sh=[6:5], n=[11:7]. For n!=0: op=sh, cnt=n.
//     n==0 special cases:
//       LSL: pass, C=CarryIn.
//       LSR: cnt=WIDTH (O=0, C=Rm[31]).
//       ASR: cnt=WIDTH (sign fill, C=Rm[31]).
//       ROR: RRX, O={CarryIn,Rm[WIDTH-1:1]}, C=Rm[0], cnt=0.
//   [27:25]=000,[4]=1 shift reg, a=Rs[7:0].
//     a==0: pass, C=CarryIn.
//     LSL/LSR: cnt=min(a,WIDTH+1).
//     ASR: cnt=min(a,WIDTH).
//     ROR: cnt=a mod WIDTH; if a!=0 and cnt==0, then O=Rm, C=Rm[WIDTH-1].
//   [27:25]=101 branch: W=sext(imm24)<<2 to WIDTH, cnt=0, C=CarryIn.
//   other: W=zext(imm12), cnt=0, C=CarryIn.
//  SHIFT, each cycle: k=min(STEP,cnt); W shifted k positions by op; cnt-=k.
//   C = last bit shifted out (LSL: W[WIDTH-k]; others: W[k-1]).
//   Fill: LSL/LSR zeros, ASR copies W[WIDTH-1], ROR wraps.
//   On cnt==0 (including the load value 0): O<=W, CarryOut<=C, go to DONE.
//  Latency: Done high ceil(cnt/STEP)+1 cycles after the Start edge (cnt=0 -> 1 cycle).
//  Busy=1 exactly in SHIFT; Done=1 exactly in DONE. O/CarryOut hold between operations.
//  cnt width is clog2(WIDTH+2). No combinational path from inputs to outputs.
// TESTING
//  WIDTH=32,STEP=1, rotate imm instr 0x020004FF -> O=0xFF000000, CarryOut=1, Done 9 cycles after Start.
//  Shift imm LSR #0, Rm=0x80000001 -> O=0x00000000, CarryOut=1, Done 33 cycles after Start.
//  Shift reg ASR, Rs=40, Rm=0x80000000 -> O=0xFFFFFFFF, CarryOut=1.
//    Repeat with STEP=8: Done after 5 cycles.
//  RRX (ROR #0), CarryIn=1, Rm=0x00000003 -> O=0x80000001, CarryOut=1, Done after 1 cycle.
//    Also: LSL reg Rs=33 -> O=0, CarryOut=0.
//  Branch imm24=0xFFFFFE -> O=0xFFFFFFF8, CarryOut=CarryIn.
//    Second Start while Busy is ignored (O unchanged until the first op's Done).
//  Reset=0 mid-SHIFT -> next cycle O=0, Busy=0, Done=0. A new Start then completes normally.

Source files
------------

// File: rtl/shifter_seq.sv
// Multi-cycle operand-2 shifter: decodes the instruction class, then walks the
// working value STEP bit positions per clock until the count reaches zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for Start; O/CarryOut hold the last result
// SHIFT | iterating; W/C/cnt updated each cycle, result published at cnt==0
// DONE  | one-cycle completion pulse, then back to IDLE
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      InstructionReg,
  input  logic [WIDTH-1:0] Rm,
  input  logic [WIDTH-1:0] Rs,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] O,
  output logic             CarryOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11} op_t;

  state_t state, state_nxt;
  op_t op, ld_op;
  logic [WIDTH-1:0] w, ld_w, sh_w, ror_w;
  logic c, ld_c, sh_c;
  logic [CW-1:0] cnt, ld_cnt, k;
  logic [WIDTH:0] lsl_ext, lsr_ext, asr_ext;

  logic [2:0] cls;
  logic       reg_form;
  logic [1:0] sh;
  logic [4:0] n;
  logic [3:0] rot;
  logic [7:0] amt;
  logic       unused_bits;

  assign cls      = InstructionReg[27:25];
  assign reg_form = InstructionReg[4];
  assign sh       = InstructionReg[6:5];
  assign n        = InstructionReg[11:7];
  assign rot      = InstructionReg[11:8];
  assign amt      = Rs[7:0];
  // Condition field and the upper register bits never affect the shift.
  assign unused_bits = ^{InstructionReg[31:28], Rs[WIDTH-1:8]};

  // Operand decode: initial working value, carry, count and operation.
  always_comb begin
    ld_w   = Rm;
    ld_c   = CarryIn;
    ld_cnt = '0;
    ld_op  = OP_LSL;
    case (cls)
      3'b001: begin
        ld_w   = {{(WIDTH-8){1'b0}}, InstructionReg[7:0]};
        ld_op  = OP_ROR;
        ld_cnt = {{(CW-5){1'b0}}, rot, 1'b0};
      end
      3'b000: begin
        ld_op = op_t'(sh);
        if (!reg_form) begin
          if (n != 5'd0) begin
            ld_cnt = {{(CW-5){1'b0}}, n};
          end else begin
            case (ld_op)
              OP_LSR, OP_ASR: ld_cnt = CW'(WIDTH);
              OP_ROR: begin
                // RRX: one-bit rotate through carry, finished at load.
                ld_w = {CarryIn, Rm[WIDTH-1:1]};
                ld_c = Rm[0];
              end
              default: ;
            endcase
          end
        end else if (amt != 8'd0) begin
          case (ld_op)
            OP_LSL, OP_LSR: ld_cnt = (int'(amt) > WIDTH + 1) ? CW'(WIDTH + 1) : CW'(amt);
            OP_ASR:         ld_cnt = (int'(amt) > WIDTH) ? CW'(WIDTH) : CW'(amt);
            default: begin
              ld_cnt = CW'(int'(amt) % WIDTH);
              // Rotate by a whole multiple of WIDTH: value unchanged, carry is the MSB.
              if ((int'(amt) % WIDTH) == 0) ld_c = Rm[WIDTH-1];
            end
          endcase
        end
      end
      3'b101: ld_w = {{(WIDTH-26){InstructionReg[23]}}, InstructionReg[23:0], 2'b00};
      default: ld_w = {{(WIDTH-12){1'b0}}, InstructionReg[11:0]};
    endcase
  end

  // One iteration of the shift: k positions, carry is the last bit shifted out.
  always_comb begin
    k       = (cnt < CW'(STEP)) ? cnt : CW'(STEP);
    lsl_ext = {1'b0, w} << k;
    lsr_ext = {w, 1'b0} >> k;
    asr_ext = $signed({w, 1'b0}) >>> k;
    ror_w   = (w >> k) | (w << (CW'(WIDTH) - k));
    sh_w    = w;
    sh_c    = c;
    case (op)
      OP_LSL: begin sh_w = lsl_ext[WIDTH-1:0]; sh_c = lsl_ext[WIDTH]; end
      OP_LSR: begin sh_w = lsr_ext[WIDTH:1];   sh_c = lsr_ext[0];     end
      OP_ASR: begin sh_w = asr_ext[WIDTH:1];   sh_c = asr_ext[0];     end
      default: begin sh_w = ror_w;             sh_c = ror_w[WIDTH-1]; end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; Start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on Start, iterate in SHIFT, publish result when the count runs out.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      w        <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      op       <= OP_LSL;
      O        <= '0;
      CarryOut <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            w   <= ld_w;
            c   <= ld_c;
            cnt <= ld_cnt;
            op  <= ld_op;
          end
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            O        <= w;
            CarryOut <= c;
          end else begin
            w   <= sh_w;
            c   <= sh_c;
            cnt <= cnt - k;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state == S_SHIFT);
  assign Done = (state == S_DONE);

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq: one STEP=1 instance for all scenarios and a
// STEP=8 instance for the multi-bit-per-cycle latency case.
module tb_shifter_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start1, start8;
  logic [31:0] instr, rm, rs;
  logic        cin;
  logic [31:0] o1, o8;
  logic        co1, co8, busy1, busy8, done1, done8;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  shifter_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start1), .InstructionReg(instr), .Rm(rm), .Rs(rs),
    .CarryIn(cin), .O(o1), .CarryOut(co1), .Busy(busy1), .Done(done1));

  shifter_seq #(.WIDTH(32), .STEP(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(start8), .InstructionReg(instr), .Rm(rm), .Rs(rs),
    .CarryIn(cin), .O(o8), .CarryOut(co8), .Busy(busy8), .Done(done8));

  // Drive one operation into dut1 and return cycles from the Start edge to Done (-1 on timeout).
  task automatic run_op(input logic [31:0] i, input logic [31:0] m, input logic [31:0] s,
                        input logic ci, output int lat);
    @(negedge Clk);
    instr = i; rm = m; rs = s; cin = ci; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin @(negedge Clk); lat++; end
    if (done1 !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_vec++; if (o1 !== 32'h0) begin n_err++; $display("FAIL reset_o: got %h expected %h", o1, 32'h0); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", co1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done1); end
    Reset = 1'b1;
  endtask

  task automatic test_rotate_imm();
    int lat;
    run_op(32'h020004FF, 32'h0, 32'h0, 1'b0, lat);
    n_vec++; if (o1 !== 32'hFF000000) begin n_err++; $display("FAIL rot_imm_o: got %h expected %h", o1, 32'hFF000000); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL rot_imm_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL rot_imm_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_shift_imm();
    int lat;
    // LSR #0 means LSR #32
    run_op(32'h00000020, 32'h80000001, 32'h0, 1'b0, lat);
    n_vec++; if (o1 !== 32'h0) begin n_err++; $display("FAIL lsr0_o: got %h expected %h", o1, 32'h0); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL lsr0_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 33) begin n_err++; $display("FAIL lsr0_latency: got %0d expected 33", lat); end
    // LSL #4
    run_op(32'h00000200, 32'h1000000F, 32'h0, 1'b0, lat);
    n_vec++; if (o1 !== 32'h000000F0) begin n_err++; $display("FAIL lsl4_o: got %h expected %h", o1, 32'h000000F0); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL lsl4_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL lsl4_latency: got %0d expected 5", lat); end
    // LSL #0 passes Rm with carry unchanged
    run_op(32'h00000000, 32'h00001234, 32'h0, 1'b1, lat);
    n_vec++; if (o1 !== 32'h00001234) begin n_err++; $display("FAIL lsl0_o: got %h expected %h", o1, 32'h00001234); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL lsl0_carry: got %b expected 1", co1); end
  endtask

  task automatic test_rrx();
    int lat;
    run_op(32'h00000060, 32'h00000003, 32'h0, 1'b1, lat);
    n_vec++; if (o1 !== 32'h80000001) begin n_err++; $display("FAIL rrx_o: got %h expected %h", o1, 32'h80000001); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL rrx_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL rrx_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_shift_reg();
    int lat, lat1, lat8;
    // ASR by 40 clamps to 32; run both instances together
    @(negedge Clk);
    instr = 32'h00000050; rm = 32'h80000000; rs = 32'd40; cin = 1'b0;
    start1 = 1'b1; start8 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0; start8 = 1'b0;
    lat = 0; lat1 = -1; lat8 = -1;
    while ((lat1 < 0 || lat8 < 0) && lat < 200) begin
      @(negedge Clk); lat++;
      if (done1 === 1'b1 && lat1 < 0) lat1 = lat;
      if (done8 === 1'b1 && lat8 < 0) lat8 = lat;
    end
    n_vec++; if (o1 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL asr_reg_o: got %h expected %h", o1, 32'hFFFFFFFF); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL asr_reg_carry: got %b expected 1", co1); end
    n_vec++; if (lat1 != 33) begin n_err++; $display("FAIL asr_reg_latency: got %0d expected 33", lat1); end
    n_vec++; if (o8 !== 32'hFFFFFFFF) begin n_err++; $display("FAIL asr_reg_step8_o: got %h expected %h", o8, 32'hFFFFFFFF); end
    n_vec++; if (co8 !== 1'b1) begin n_err++; $display("FAIL asr_reg_step8_carry: got %b expected 1", co8); end
    n_vec++; if (lat8 != 5) begin n_err++; $display("FAIL asr_reg_step8_latency: got %0d expected 5", lat8); end
    // LSL by 33: result 0, carry 0 even with all ones
    run_op(32'h00000010, 32'hFFFFFFFF, 32'd33, 1'b1, lat);
    n_vec++; if (o1 !== 32'h0) begin n_err++; $display("FAIL lsl33_o: got %h expected %h", o1, 32'h0); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL lsl33_carry: got %b expected 0", co1); end
    n_vec++; if (lat != 34) begin n_err++; $display("FAIL lsl33_latency: got %0d expected 34", lat); end
    // ROR by 32: value unchanged, carry = MSB
    run_op(32'h00000070, 32'h80000005, 32'd32, 1'b0, lat);
    n_vec++; if (o1 !== 32'h80000005) begin n_err++; $display("FAIL ror32_o: got %h expected %h", o1, 32'h80000005); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL ror32_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL ror32_latency: got %0d expected 1", lat); end
    // ROR by 4
    run_op(32'h00000070, 32'h0000001F, 32'd4, 1'b0, lat);
    n_vec++; if (o1 !== 32'hF0000001) begin n_err++; $display("FAIL ror4_o: got %h expected %h", o1, 32'hF0000001); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL ror4_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL ror4_latency: got %0d expected 5", lat); end
    // Register amount 0: pass with carry unchanged
    run_op(32'h00000030, 32'hA5A5A5A5, 32'h00000100, 1'b0, lat);
    n_vec++; if (o1 !== 32'hA5A5A5A5) begin n_err++; $display("FAIL reg0_o: got %h expected %h", o1, 32'hA5A5A5A5); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL reg0_carry: got %b expected 0", co1); end
  endtask

  task automatic test_branch_imm12();
    int lat;
    run_op(32'h0AFFFFFE, 32'h0, 32'h0, 1'b1, lat);
    n_vec++; if (o1 !== 32'hFFFFFFF8) begin n_err++; $display("FAIL branch_o: got %h expected %h", o1, 32'hFFFFFFF8); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL branch_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL branch_latency: got %0d expected 1", lat); end
    run_op(32'h04000ABC, 32'hFFFFFFFF, 32'h0, 1'b0, lat);
    n_vec++; if (o1 !== 32'h00000ABC) begin n_err++; $display("FAIL imm12_o: got %h expected %h", o1, 32'h00000ABC); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL imm12_carry: got %b expected 0", co1); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h0AFFFFFE, 32'h0, 32'h0, 1'b0, lat);
    // LSL #4, with a second Start (rotate imm) pulsed while busy
    @(negedge Clk);
    instr = 32'h00000200; rm = 32'h1000000F; rs = 32'h0; cin = 1'b0; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 200) begin
      @(negedge Clk); lat++;
      if (lat == 1) begin instr = 32'h020004FF; start1 = 1'b1; end
      if (lat == 2) begin
        start1 = 1'b0;
        n_vec++; if (o1 !== 32'hFFFFFFF8) begin n_err++; $display("FAIL b2b_hold_o: got %h expected %h", o1, 32'hFFFFFFF8); end
        n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy1); end
      end
    end
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
    n_vec++; if (o1 !== 32'h000000F0) begin n_err++; $display("FAIL b2b_o: got %h expected %h", o1, 32'h000000F0); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL b2b_carry: got %b expected 1", co1); end
    repeat (3) @(negedge Clk);
    n_vec++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin n_err++; $display("FAIL b2b_no_restart: got busy=%b done=%b expected 0 0", busy1, done1); end
    n_vec++; if (o1 !== 32'h000000F0) begin n_err++; $display("FAIL b2b_result_hold: got %h expected %h", o1, 32'h000000F0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge Clk);
    instr = 32'h00000020; rm = 32'h80000001; rs = 32'h0; cin = 1'b0; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_vec++; if (o1 !== 32'h0) begin n_err++; $display("FAIL midreset_o: got %h expected %h", o1, 32'h0); end
    n_vec++; if (co1 !== 1'b0) begin n_err++; $display("FAIL midreset_carry: got %b expected 0", co1); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy1); end
    n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done1); end
    Reset = 1'b1;
    run_op(32'h020004FF, 32'h0, 32'h0, 1'b0, lat);
    n_vec++; if (o1 !== 32'hFF000000) begin n_err++; $display("FAIL postreset_o: got %h expected %h", o1, 32'hFF000000); end
    n_vec++; if (co1 !== 1'b1) begin n_err++; $display("FAIL postreset_carry: got %b expected 1", co1); end
    n_vec++; if (lat != 9) begin n_err++; $display("FAIL postreset_latency: got %0d expected 9", lat); end
  endtask

  initial begin
    Reset = 1'b0; start1 = 1'b0; start8 = 1'b0;
    instr = 32'h0; rm = 32'h0; rs = 32'h0; cin = 1'b0;
    test_reset();
    test_rotate_imm();
    test_shift_imm();
    test_rrx();
    test_shift_reg();
    test_branch_imm12();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
